// File: rtl/store_run_guard.sv
// Tracks contiguous non-frame store runs, commits long runs into a circular range table,
// and flags loads that fall inside a committed or live run on the following cycle.
module store_run_guard #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 10,
  parameter int unsigned MIN_RUN = 32,
  parameter int unsigned DATE_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic                       is_store_i,
  input  logic                       is_load_i,
  input  logic [3:0]                 size_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       frame_base_i,
  input  logic                       mode_i,
  output logic                       hit_o,
  output logic                       violation_o,
  output logic                       commit_o,
  output logic                       tracking_o,
  output logic [$clog2(DEPTH+1)-1:0] entries_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   start_q, end_q;
  logic [DATE_W-1:0]   date_q;
  logic [ADDR_W-1:0]   tstart_q [DEPTH];
  logic [ADDR_W-1:0]   tend_q   [DEPTH];
  logic [DEPTH-1:0]    tvalid_q;
  logic [PtrW-1:0]     wptr_q;
  logic [CntW-1:0]     count_q;
  logic                commit_q, hit_q, viol_q;

  logic                trk_store, other_op, load_chk;
  logic [ADDR_W-1:0]   size_ext, new_end, run_len;
  logic [ADDR_W:0]     ext_sum;
  logic                in_track, contig, extend, wrap_break, restart, timeout_close;
  logic                do_commit, tbl_hit, live_hit, hit_d;

  always_comb begin
    trk_store = valid_i & is_store_i & ~frame_base_i;
    other_op  = valid_i & ~trk_store;
    // Store wins when both flags are set, so no check happens on that cycle.
    load_chk  = valid_i & is_load_i & ~is_store_i;

    size_ext  = {{(ADDR_W-4){1'b0}}, size_i};
    new_end   = addr_i + size_ext;
    ext_sum   = {1'b0, end_q} + {1'b0, size_ext};
    run_len   = end_q - start_q;

    in_track      = (state_q == StTrack);
    contig        = in_track & trk_store & (addr_i == end_q);
    extend        = contig & ~ext_sum[ADDR_W];
    wrap_break    = contig & ext_sum[ADDR_W];
    restart       = in_track & trk_store & ~extend;
    timeout_close = in_track & other_op & (date_q == '0);
    do_commit     = (restart | timeout_close) & ~wrap_break & (run_len > ADDR_W'(MIN_RUN));

    tbl_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tvalid_q[k] && (addr_i >= tstart_q[k]) && (addr_i < tend_q[k])) tbl_hit = 1'b1;
    end
    // Live run compare covers the closing cycle before the table write lands.
    live_hit = in_track & (addr_i >= start_q) & (addr_i < end_q);
    hit_d    = load_chk & (tbl_hit | live_hit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      start_q  <= '0;
      end_q    <= '0;
      date_q   <= '0;
      tvalid_q <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
      hit_q    <= 1'b0;
      viol_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        tstart_q[k] <= '0;
        tend_q[k]   <= '0;
      end
    end else if (flush_i) begin
      state_q  <= StIdle;
      start_q  <= '0;
      end_q    <= '0;
      date_q   <= '0;
      tvalid_q <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
      hit_q    <= 1'b0;
      viol_q   <= 1'b0;
    end else begin
      commit_q <= do_commit;
      hit_q    <= hit_d;
      viol_q   <= hit_d & mode_i;

      if (do_commit) begin
        tstart_q[wptr_q] <= start_q;
        tend_q[wptr_q]   <= end_q;
        tvalid_q[wptr_q] <= 1'b1;
        wptr_q           <= wptr_q + 1'b1;
        if (count_q != CntW'(DEPTH)) count_q <= count_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (trk_store) begin
            start_q <= addr_i;
            end_q   <= new_end;
            date_q  <= DATE_W'(TIMEOUT);
            state_q <= StTrack;
          end
        end
        StTrack: begin
          if (trk_store) begin
            date_q <= DATE_W'(TIMEOUT);
            if (extend) begin
              end_q <= ext_sum[ADDR_W-1:0];
            end else begin
              start_q <= addr_i;
              end_q   <= new_end;
            end
          end else if (other_op) begin
            if (date_q == '0) state_q <= StIdle;
            else              date_q  <= date_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hit_o       = hit_q;
  assign violation_o = viol_q;
  assign commit_o    = commit_q;
  assign tracking_o  = (state_q == StTrack);
  assign entries_o   = count_q;

endmodule

// File: tb/tb_store_run_guard.sv
// Directed bench for store_run_guard: run commit, timeout, restart, table wrap-around,
// frame-base filtering, async reset, address wrap, monitor mode and flush.
module tb_store_run_guard;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, is_store_i, is_load_i, frame_base_i, mode_i;
  logic [3:0]  size_i;
  logic [31:0] addr_i;
  logic        hit_o, violation_o, commit_o, tracking_o;
  logic [3:0]  entries_o;

  int checks = 0;
  int failures = 0;

  store_run_guard dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .is_store_i   (is_store_i),
    .is_load_i    (is_load_i),
    .size_i       (size_i),
    .addr_i       (addr_i),
    .frame_base_i (frame_base_i),
    .mode_i       (mode_i),
    .hit_o        (hit_o),
    .violation_o  (violation_o),
    .commit_o     (commit_o),
    .tracking_o   (tracking_o),
    .entries_o    (entries_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v, input logic st, input logic ld, input logic [3:0] sz,
                    input logic [31:0] a, input logic fb);
    valid_i = v; is_store_i = st; is_load_i = ld; size_i = sz; addr_i = a; frame_base_i = fb;
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] sz);
    op(1'b1, 1'b1, 1'b0, sz, a, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a);
    op(1'b1, 1'b0, 1'b1, 4'd4, a, 1'b0);
  endtask

  task automatic alu(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 1'b0, 1'b0, 4'd4, 32'h0, 1'b0);
  endtask

  task automatic do_flush();
    flush_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; is_store_i = 1'b0; is_load_i = 1'b0;
    size_i = 4'd4; addr_i = '0; frame_base_i = 1'b0; mode_i = 1'b1;
    #1;
    chk("rst_hit", hit_o, 0);
    chk("rst_viol", violation_o, 0);
    chk("rst_commit", commit_o, 0);
    chk("rst_track", tracking_o, 0);
    chk("rst_entries", entries_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // 36-byte run, closed by timeout after the 11th non-store op
    for (int i = 0; i < 9; i++) st(32'h1000 + 4 * i, 4'd4);
    chk("t1_track", tracking_o, 1);
    alu(10);
    chk("t1_no_commit_yet", commit_o, 0);
    chk("t1_still_track", tracking_o, 1);
    alu(1);
    chk("t1_commit", commit_o, 1);
    chk("t1_entries", entries_o, 1);
    chk("t1_idle", tracking_o, 0);
    ld(32'h1010);
    chk("t1_hit", hit_o, 1);
    chk("t1_viol", violation_o, 1);
    chk("t1_commit_pulse", commit_o, 0);
    alu(1);
    chk("t1_hit_clear", hit_o, 0);

    // Monitor mode, then flush
    mode_i = 1'b0;
    ld(32'h1023);
    chk("mon_hit", hit_o, 1);
    chk("mon_viol", violation_o, 0);
    ld(32'h1024);
    chk("t1_end_excl", hit_o, 0);
    do_flush();
    chk("flush_entries", entries_o, 0);
    ld(32'h1010);
    chk("flush_miss", hit_o, 0);

    // 32-byte run: live hit, then timeout with no commit
    for (int i = 0; i < 8; i++) st(32'h2000 + 4 * i, 4'd4);
    ld(32'h2004);
    chk("t2_live_hit", hit_o, 1);
    alu(9);
    chk("t2_track", tracking_o, 1);
    alu(1);
    chk("t2_idle", tracking_o, 0);
    chk("t2_no_commit", commit_o, 0);
    chk("t2_entries", entries_o, 0);
    ld(32'h2004);
    chk("t2_miss", hit_o, 0);

    // Restart on break
    for (int i = 0; i < 9; i++) st(32'h3000 + 4 * i, 4'd4);
    st(32'h5000, 4'd1);
    chk("t3_commit", commit_o, 1);
    chk("t3_track", tracking_o, 1);
    chk("t3_entries", entries_o, 1);
    ld(32'h5000);
    chk("t3_live_hit", hit_o, 1);
    ld(32'h3020);
    chk("t3_tbl_hit", hit_o, 1);
    ld(32'h5001);
    chk("t3_live_end", hit_o, 0);

    // DEPTH+1 runs: table wraps and evicts the oldest
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 9; i++) begin
        st(32'h100 * k + 4 * i, 4'd4);
        if (i == 0) chk($sformatf("t4_restart_commit_%0d", k), commit_o, (k == 0) ? 0 : 1);
      end
    end
    alu(11);
    chk("t4_last_commit", commit_o, 1);
    chk("t4_entries_sat", entries_o, 8);
    ld(32'h0010);
    chk("t4_first_evicted", hit_o, 0);
    ld(32'h3000);
    chk("t4_old_evicted", hit_o, 0);
    ld(32'h0810);
    chk("t4_last_hit", hit_o, 1);
    ld(32'h0110);
    chk("t4_second_hit", hit_o, 1);

    // Frame-base stores are ignored; async reset mid-run
    for (int i = 0; i < 9; i++) op(1'b1, 1'b1, 1'b0, 4'd4, 32'h7000 + 4 * i, 1'b1);
    chk("t5_fb_idle", tracking_o, 0);
    for (int i = 0; i < 9; i++) st(32'h6000 + 4 * i, 4'd4);
    ld(32'h6000);
    chk("t5_pre_rst_hit", hit_o, 1);
    rst_i = 1'b1;
    #1;
    chk("t5_rst_track", tracking_o, 0);
    chk("t5_rst_entries", entries_o, 0);
    chk("t5_rst_hit", hit_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    alu(12);
    chk("t5_no_commit", commit_o, 0);
    chk("t5_entries", entries_o, 0);

    // Address wrap closes the run without commit
    for (int i = 0; i < 9; i++) st(32'hFFFF_FFD8 + 4 * i, 4'd4);
    st(32'hFFFF_FFFC, 4'd8);
    chk("t6_wrap_no_commit", commit_o, 0);
    chk("t6_wrap_track", tracking_o, 1);
    ld(32'hFFFF_FFE0);
    chk("t6_wrap_miss", hit_o, 0);
    chk("t6_entries", entries_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
